// File: rtl/btn_event_decoder.sv
// rtl/btn_event_decoder.sv - classifies a debounced button into short, double, long and repeat events
// One shared counter times press length, release gap and repeat period; all outputs are registered.
module btn_event_decoder #(
  parameter int LONG_CNT   = 1000,
  parameter int GAP_CNT    = 250,
  parameter int REPEAT_CNT = 200,
  parameter int CNT_W      = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic short_press,
  output logic double_press,
  output logic long_press,
  output logic repeat_pulse,
  output logic held
);

  typedef enum logic [2:0] {
    IDLE,
    PRESS1,
    WAIT_GAP,
    PRESS2,
    LONG_HELD
  } state_t;

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CNT - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CNT - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = (REPEAT_CNT == 0) ? '0 : CNT_W'(REPEAT_CNT - 1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             short_nxt;
  logic             double_nxt;
  logic             long_nxt;
  logic             repeat_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      short_press  <= 1'b0;
      double_press <= 1'b0;
      long_press   <= 1'b0;
      repeat_pulse <= 1'b0;
      held         <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      short_press  <= short_nxt;
      double_press <= double_nxt;
      long_press   <= long_nxt;
      repeat_pulse <= repeat_nxt;
      held         <= (state_nxt == LONG_HELD);
    end
  end

  // Each branch either leaves the state with cnt cleared or advances cnt below its limit.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    short_nxt  = 1'b0;
    double_nxt = 1'b0;
    long_nxt   = 1'b0;
    repeat_nxt = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (btn) state_nxt = PRESS1;
      end
      PRESS1: begin
        if (!btn) begin
          state_nxt = WAIT_GAP;
          cnt_nxt   = '0;
        end else if (cnt == LONG_LAST) begin
          state_nxt = LONG_HELD;
          cnt_nxt   = '0;
          long_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      WAIT_GAP: begin
        // A new press on the final gap cycle still counts as the second press.
        if (btn) begin
          state_nxt = PRESS2;
          cnt_nxt   = '0;
        end else if (cnt == GAP_LAST) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          short_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      PRESS2: begin
        cnt_nxt = '0;
        if (!btn) begin
          state_nxt  = IDLE;
          double_nxt = 1'b1;
        end
      end
      LONG_HELD: begin
        if (!btn) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (REPEAT_CNT != 0) begin
          if (cnt == REP_LAST) begin
            cnt_nxt    = '0;
            repeat_nxt = 1'b1;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_btn_event_decoder.sv
// tb/tb_btn_event_decoder.sv - directed and random checks of btn_event_decoder against a run-length model
module tb_btn_event_decoder;
  localparam int L = 8;
  localparam int G = 4;
  localparam int R = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn = 1'b0;
  logic s_p, d_p, l_p, r_p, h_l;
  logic s_0, d_0, l_0, r_0, h_0;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_on = 0;

  btn_event_decoder #(.LONG_CNT(L), .GAP_CNT(G), .REPEAT_CNT(R), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .btn(btn),
    .short_press(s_p), .double_press(d_p), .long_press(l_p), .repeat_pulse(r_p), .held(h_l)
  );

  btn_event_decoder #(.LONG_CNT(L), .GAP_CNT(G), .REPEAT_CNT(0), .CNT_W(16)) dut_norep (
    .clk(clk), .rst(rst), .btn(btn),
    .short_press(s_0), .double_press(d_0), .long_press(l_0), .repeat_pulse(r_0), .held(h_0)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a sequence is a run of high samples, a run of low samples, maybe a second high run.
  int phase, high_len, low_len;   // phase: 0 none, 1 first press, 2 gap, 3 second press, 4 long hold
  bit e_s, e_d, e_l, e_r, e_r0, e_h;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      phase = 0; high_len = 0; low_len = 0;
      e_s = 0; e_d = 0; e_l = 0; e_r = 0; e_r0 = 0; e_h = 0;
    end else begin
      e_s = 0; e_d = 0; e_l = 0; e_r = 0; e_r0 = 0;
      case (phase)
        0: if (btn) begin phase = 1; high_len = 1; end
        1: if (btn) begin
             high_len++;
             if (high_len == L + 1) begin phase = 4; e_l = 1; end
           end else begin
             phase = 2; low_len = 1;
           end
        2: if (btn) phase = 3;
           else begin
             low_len++;
             if (low_len == G + 1) begin phase = 0; e_s = 1; end
           end
        3: if (!btn) begin phase = 0; e_d = 1; end
        default: if (btn) begin
             high_len++;
             if ((high_len - (L + 1)) % R == 0) e_r = 1;
           end else phase = 0;
      endcase
      e_h = (phase == 4);
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("short", int'(s_p), int'(e_s));
      chk("double", int'(d_p), int'(e_d));
      chk("long", int'(l_p), int'(e_l));
      chk("repeat", int'(r_p), int'(e_r));
      chk("held", int'(h_l), int'(e_h));
      chk("one_pulse", int'($countones({s_p, d_p, l_p, r_p}) <= 1), 1);
      chk("norep_short", int'(s_0), int'(e_s));
      chk("norep_double", int'(d_0), int'(e_d));
      chk("norep_long", int'(l_0), int'(e_l));
      chk("norep_repeat", int'(r_0), int'(e_r0));
      chk("norep_held", int'(h_0), int'(e_h));
    end
  end

  int f_s, f_d, f_l, f_r, f_h, z_r;
  int c_s, c_d, c_l, c_r, c_h;

  // Cycle k: outputs observed for cycle k, then btn driven with pat[k] for sampling at the next edge.
  task automatic run_pat(input logic [63:0] pat, input int len, input int rst_at);
    f_s = -1; f_d = -1; f_l = -1; f_r = -1; f_h = -1; z_r = -1;
    c_s = 0; c_d = 0; c_l = 0; c_r = 0; c_h = 0;
    for (int k = 0; k < len; k++) begin
      @(negedge clk);
      if (s_p) begin c_s++; if (f_s < 0) f_s = k; end
      if (d_p) begin c_d++; if (f_d < 0) f_d = k; end
      if (l_p) begin c_l++; if (f_l < 0) f_l = k; end
      if (r_p) begin c_r++; if (f_r < 0) f_r = k; z_r = k; end
      if (h_l) begin c_h++; if (f_h < 0) f_h = k; end
      if (k == rst_at) begin
        rst = 1'b1;
        #1;
        chk("rst_async_outs", int'({s_p, d_p, l_p, r_p, h_l}), 0);
      end
      if (k == rst_at + 1) rst = 1'b0;
      btn = pat[k];
    end
  endtask

  initial begin
    #12;
    chk("reset_outs", int'({s_p, d_p, l_p, r_p, h_l, s_0, d_0, l_0, r_0, h_0}), 0);
    @(negedge clk);
    rst = 1'b0;
    chk_on = 1;
    repeat (3) @(negedge clk);

    run_pat(64'h7, 40, -5);
    chk("A_short_at", f_s, 8);
    chk("A_short_cnt", c_s, 1);
    chk("A_others", c_d + c_l + c_r + c_h, 0);

    run_pat(64'h33, 40, -5);
    chk("B_double_at", f_d, 7);
    chk("B_double_cnt", c_d, 1);
    chk("B_short_cnt", c_s, 0);

    run_pat(64'h1F_FFFF, 40, -5);
    chk("C_long_at", f_l, 9);
    chk("C_long_cnt", c_l, 1);
    chk("C_held_first", f_h, 9);
    chk("C_held_cnt", c_h, 13);
    chk("C_rep_first", f_r, 12);
    chk("C_rep_last", z_r, 21);
    chk("C_rep_cnt", c_r, 4);

    run_pat(64'h43, 40, -5);
    chk("D_short_cnt", c_s, 0);
    chk("D_double_at", f_d, 8);

    run_pat(64'h1F_FFFF, 40, 5);
    chk("E_long_at", f_l, 15);
    chk("E_long_cnt", c_l, 1);

    run_pat(64'h333, 40, -5);
    chk("F_double_at", f_d, 7);
    chk("F_short_at", f_s, 15);

    // Random runs of 1..14 cycles exercise every boundary around G and L.
    begin
      int left;
      bit lvl;
      left = 0; lvl = 0;
      for (int k = 0; k < 10000; k++) begin
        @(negedge clk);
        if (left == 0) begin
          lvl  = ~lvl;
          left = $urandom_range(1, 14);
        end
        btn = lvl;
        left--;
      end
    end
    @(negedge clk);
    btn = 1'b0;
    repeat (20) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
